change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Coin-return side of the vending machine. Accepts a change request (amount in units) and pays it out as single-cycle coin-eject pulses on three ejectors: 10, 5 and 1.
- Picks the largest coin first and tracks per-denomination inventory.
- If the amount cannot be paid in full, it flags a shortfall.
- Sits between the vend controller's change/credit output and the physical coin ejector drivers.

Parameters:
- CNT_W, 5, width of amount and remaining-credit datapath.
- INV_W, 4, width of each per-denomination inventory counter.
- INIT_INV, 8, inventory loaded into all three counters at reset (must fit INV_W).
- GAP_CYCLES, 4, idle cycles inserted after each eject pulse (0 allowed).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- req  in  1  change request strobe, sampled in IDLE only.
- amount  in  CNT_W  units to return, captured with req.
- refill  in  1  inventory load strobe, honoured in IDLE only.
- refill_10 / refill_5 / refill_1  in  INV_W each  new inventory values loaded on refill.
- out10 / out5 / out1  out  1 each  one-cycle eject pulse for that coin.
- busy  out  1  high from the cycle after req acceptance until the DONE/ERROR cycle inclusive.
- done  out  1  one-cycle pulse: amount fully paid.
- short_err  out  1  one-cycle pulse: inventory exhausted before amount paid.
- remaining  out  CNT_W  credit still owed. Live during operation; held after ERROR until next accepted req.
- coin_empty  out  3  {10,5,1} inventory counter == 0, combinational from counters.

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE.
  - All pulses, busy, done and short_err = 0.
  - remaining=0.
  - Inventories = INIT_INV.
  - Reset mid-payout aborts immediately; coins already ejected are not restored.
- Reset dominates all other inputs.
- All outputs except coin_empty are registered.
- States: IDLE, SELECT, EJECT, GAP, DONE, ERROR.
- IDLE:
  - refill==1 loads all three inventories from refill_* (same edge).
  - req==1 latches remaining=amount and moves to SELECT.
  - req and refill together: both take effect; SELECT sees the refilled inventory.
  - req with amount==0 goes to SELECT, which goes straight to DONE (no coins).
- req and refill while not in IDLE are ignored. No queuing.
- SELECT (1 cycle), coin choice in priority order:
  - remaining==0 → DONE.
  - remaining>=10 and inv10>0 → EJECT(10).
  - else remaining>=5 and inv5>0 → EJECT(5).
  - else inv1>0 → EJECT(1).
  - else → ERROR.
- EJECT (1 cycle):
  - Chosen outN=1.
  - remaining -= N and that inventory -= 1, both on exit edge.
  - Then GAP if GAP_CYCLES>0, else SELECT.
  - Exactly one out* high in any cycle.
- GAP: counter runs GAP_CYCLES cycles with all out*=0, then SELECT.
- DONE: done=1 for one cycle, busy still 1, then IDLE (busy=0).
- ERROR: short_err=1 for one cycle, then IDLE. remaining keeps unpaid amount.
- Latency:
  - req sampled at edge k.
  - First eject pulse in cycle k+2.
  - Coin period = 2+GAP_CYCLES cycles.
  - done asserted 2 cycles after the final GAP (SELECT then DONE).
- Arithmetic:
  - remaining never underflows, because a coin is only chosen when remaining>=N.
  - Inventory never underflows, because a coin is only chosen when its inventory>0.
  - No wrap on either.

Test Plan:
- Reset, req amount=15, GAP=4 → out10 pulse at k+2, out5 at k+8, done at k+14. inv10=7, inv5=7, remaining=0, busy low after done.
- refill 10/5/1 = 0/2/8, req amount=13 → out5, out5, out1, out1, out1, done. Final inv5=0, inv1=5, coin_empty=3'b110.
- refill 0/0/2, req amount=4 → out1, out1, then short_err pulse. remaining=2 held; coin_empty=3'b111.
- req amount=0 → no out* pulses, done at k+2, busy high only cycles k+1..k+2.
- req amount=19 accepted, then req/refill pulses mid-payout → ignored. Pulses out10, out5, four out1, then done; inventory unchanged by the refill.
- rst low during GAP after first out10 of amount=20 → next cycle all outputs 0, state IDLE, inventories back to 8/8/8. No further pulses.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Change-request and coin-eject bundle between the vend controller and the dispenser.
interface change_dispenser_if #(
    parameter int unsigned CNT_W = 5,
    parameter int unsigned INV_W = 4
);
    logic             req;
    logic [CNT_W-1:0] amount;
    logic             refill;
    logic [INV_W-1:0] refill_10;
    logic [INV_W-1:0] refill_5;
    logic [INV_W-1:0] refill_1;
    logic             out10;
    logic             out5;
    logic             out1;
    logic             busy;
    logic             done;
    logic             short_err;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       coin_empty;

    modport master (
        output req, amount, refill, refill_10, refill_5, refill_1,
        input  out10, out5, out1, busy, done, short_err, remaining, coin_empty
    );

    modport slave (
        input  req, amount, refill, refill_10, refill_5, refill_1,
        output out10, out5, out1, busy, done, short_err, remaining, coin_empty
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays a change amount as greedy 10/5/1 coin pulses with per-coin inventory tracking.
module change_dispenser #(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned INV_W      = 4,
    parameter int unsigned INIT_INV   = 8,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_EJECT  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [1:0] COIN_10 = 2'd0;
    localparam logic [1:0] COIN_5  = 2'd1;
    localparam logic [1:0] COIN_1  = 2'd2;

    logic [2:0]       state, state_n;
    logic [1:0]       coin, coin_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [CNT_W-1:0] remaining_q, remaining_n;
    logic [INV_W-1:0] inv10, inv10_n;
    logic [INV_W-1:0] inv5, inv5_n;
    logic [INV_W-1:0] inv1, inv1_n;
    logic             out10_q, out10_n;
    logic             out5_q, out5_n;
    logic             out1_q, out1_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             short_q, short_n;

    // State, datapath and registered outputs; reset aborts any payout in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            coin        <= COIN_1;
            gap_cnt     <= '0;
            remaining_q <= '0;
            inv10       <= INV_W'(INIT_INV);
            inv5        <= INV_W'(INIT_INV);
            inv1        <= INV_W'(INIT_INV);
            out10_q     <= 1'b0;
            out5_q      <= 1'b0;
            out1_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            state       <= state_n;
            coin        <= coin_n;
            gap_cnt     <= gap_n;
            remaining_q <= remaining_n;
            inv10       <= inv10_n;
            inv5        <= inv5_n;
            inv1        <= inv1_n;
            out10_q     <= out10_n;
            out5_q      <= out5_n;
            out1_q      <= out1_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            short_q     <= short_n;
        end
    end

    // Next-state, coin choice and next values of every registered output.
    always_comb begin
        state_n     = state;
        coin_n      = coin;
        gap_n       = gap_cnt;
        remaining_n = remaining_q;
        inv10_n     = inv10;
        inv5_n      = inv5;
        inv1_n      = inv1;
        out10_n     = 1'b0;
        out5_n      = 1'b0;
        out1_n      = 1'b0;
        busy_n      = busy_q;
        done_n      = 1'b0;
        short_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.refill) begin
                    inv10_n = bus.refill_10;
                    inv5_n  = bus.refill_5;
                    inv1_n  = bus.refill_1;
                end
                if (bus.req) begin
                    remaining_n = bus.amount;
                    busy_n      = 1'b1;
                    state_n     = S_SELECT;
                end
            end
            S_SELECT: begin
                // Coins are only chosen when both credit and stock allow, so nothing underflows.
                if (remaining_q == '0) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else if (remaining_q >= CNT_W'(10) && inv10 != '0) begin
                    state_n = S_EJECT;
                    coin_n  = COIN_10;
                    out10_n = 1'b1;
                end else if (remaining_q >= CNT_W'(5) && inv5 != '0) begin
                    state_n = S_EJECT;
                    coin_n  = COIN_5;
                    out5_n  = 1'b1;
                end else if (inv1 != '0) begin
                    state_n = S_EJECT;
                    coin_n  = COIN_1;
                    out1_n  = 1'b1;
                end else begin
                    state_n = S_ERROR;
                    short_n = 1'b1;
                end
            end
            S_EJECT: begin
                case (coin)
                    COIN_10: begin
                        remaining_n = remaining_q - CNT_W'(10);
                        inv10_n     = inv10 - INV_W'(1);
                    end
                    COIN_5: begin
                        remaining_n = remaining_q - CNT_W'(5);
                        inv5_n      = inv5 - INV_W'(1);
                    end
                    default: begin
                        remaining_n = remaining_q - CNT_W'(1);
                        inv1_n      = inv1 - INV_W'(1);
                    end
                endcase
                gap_n   = '0;
                state_n = (GAP_CYCLES > 0) ? S_GAP : S_SELECT;
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    state_n = S_SELECT;
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end
            S_DONE, S_ERROR: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Drive the bus from the output registers; empty flags come straight from the counters.
    assign bus.out10      = out10_q;
    assign bus.out5       = out5_q;
    assign bus.out1       = out1_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.short_err  = short_q;
    assign bus.remaining  = remaining_q;
    assign bus.coin_empty = {inv10 == '0, inv5 == '0, inv1 == '0};
endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized checks of change_dispenser against a greedy payout model.
module tb_change_dispenser;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned INV_W    = 4;
    localparam int unsigned INIT_INV = 8;
    localparam int unsigned GAP      = 4;
    localparam int          PERIOD   = 2 + GAP;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_inv[3];

    change_dispenser_if #(.CNT_W(CNT_W), .INV_W(INV_W)) bus ();

    change_dispenser #(
        .CNT_W(CNT_W), .INV_W(INV_W), .INIT_INV(INIT_INV), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] out_vec();
        return {bus.out10, bus.out5, bus.out1, bus.busy, bus.done, bus.short_err};
    endfunction

    function automatic logic [2:0] exp_empty();
        return {m_inv[0] == 0, m_inv[1] == 0, m_inv[2] == 0};
    endfunction

    task automatic check_inv(input string tag);
        check({tag, " inv10"}, 32'(dut.inv10), 32'(m_inv[0]));
        check({tag, " inv5"},  32'(dut.inv5),  32'(m_inv[1]));
        check({tag, " inv1"},  32'(dut.inv1),  32'(m_inv[2]));
        check({tag, " coin_empty"}, 32'(bus.coin_empty), 32'(exp_empty()));
    endtask

    // One change request (optionally with a simultaneous refill), checked cycle by cycle.
    task automatic run_req(input string tag, input int amt, input bit rf,
                           input int r10, input int r5, input int r1, input bit inject);
        int coins[$];
        int rem;
        int n;
        int e;
        bit ok;
        logic [5:0] exp;
        // Model: greedy largest-coin-first payout limited by stock.
        if (rf) begin
            m_inv[0] = r10; m_inv[1] = r5; m_inv[2] = r1;
        end
        rem = amt;
        while (rem > 0) begin
            if (rem >= 10 && m_inv[0] > 0) begin
                coins.push_back(10); rem -= 10; m_inv[0]--;
            end else if (rem >= 5 && m_inv[1] > 0) begin
                coins.push_back(5); rem -= 5; m_inv[1]--;
            end else if (m_inv[2] > 0) begin
                coins.push_back(1); rem -= 1; m_inv[2]--;
            end else begin
                break;
            end
        end
        ok = (rem == 0);
        n  = coins.size();
        e  = 2 + n * PERIOD;

        bus.req       = 1'b1;
        bus.amount    = CNT_W'(amt);
        bus.refill    = rf;
        bus.refill_10 = INV_W'(r10);
        bus.refill_5  = INV_W'(r5);
        bus.refill_1  = INV_W'(r1);
        @(posedge clk);
        for (int j = 1; j <= e + 1; j++) begin
            @(negedge clk);
            if (j == 1 || (inject && j == 5)) begin
                bus.req    = 1'b0;
                bus.refill = 1'b0;
            end
            exp = '0;
            if (j >= 2 && (j - 2) % PERIOD == 0 && (j - 2) / PERIOD < n) begin
                case (coins[(j - 2) / PERIOD])
                    10:      exp[5] = 1'b1;
                    5:       exp[4] = 1'b1;
                    default: exp[3] = 1'b1;
                endcase
            end
            exp[2] = (j <= e);
            exp[1] = ok && (j == e);
            exp[0] = !ok && (j == e);
            check($sformatf("%s cyc%0d outputs", tag, j), 32'(out_vec()), 32'(exp));
            if (inject && j == 4) begin
                bus.req       = 1'b1;
                bus.amount    = CNT_W'(3);
                bus.refill    = 1'b1;
                bus.refill_10 = '0;
                bus.refill_5  = '0;
                bus.refill_1  = '0;
            end
        end
        check({tag, " remaining"}, 32'(bus.remaining), 32'(rem));
        check_inv(tag);
    endtask

    initial begin
        bus.req = 1'b0; bus.amount = '0; bus.refill = 1'b0;
        bus.refill_10 = '0; bus.refill_5 = '0; bus.refill_1 = '0;
        m_inv = '{INIT_INV, INIT_INV, INIT_INV};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", 32'(out_vec()), 32'd0);
        check("reset remaining", 32'(bus.remaining), 32'd0);
        check_inv("reset");
        rst = 1'b1;
        @(negedge clk);

        // Directed scenarios
        run_req("amt15", 15, 1'b0, 0, 0, 0, 1'b0);
        run_req("amt13", 13, 1'b1, 0, 2, 8, 1'b0);
        check("amt13 empty", 32'(bus.coin_empty), 32'(3'b110));
        run_req("short4", 4, 1'b1, 0, 0, 2, 1'b0);
        check("short4 empty", 32'(bus.coin_empty), 32'(3'b111));
        @(negedge clk);
        check("short4 held", 32'(bus.remaining), 32'd2);
        run_req("amt0", 0, 1'b0, 0, 0, 0, 1'b0);
        run_req("amt19", 19, 1'b1, 8, 8, 8, 1'b1);

        // Reset during the gap after the first 10-coin of a 20-unit payout
        bus.req = 1'b1; bus.amount = CNT_W'(20);
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("rst20 first pulse", 32'(out_vec()), 32'(6'b100100));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_inv = '{INIT_INV, INIT_INV, INIT_INV};
        check("rst20 outputs", 32'(out_vec()), 32'd0);
        check("rst20 remaining", 32'(bus.remaining), 32'd0);
        check_inv("rst20");
        rst = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check($sformatf("rst20 quiet%0d", j), 32'(out_vec()), 32'd0);
        end

        // Randomized requests with occasional refills
        for (int i = 0; i < 10; i++) begin
            bit rf;
            rf = ($urandom_range(0, 2) == 0);
            run_req($sformatf("rand%0d", i), int'($urandom_range(0, 31)), rf,
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), 1'b0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
